// File: rtl/axi4_slave_write_ctrl.sv
// AXI4 slave write-channel controller: accepts one AW burst at a time, turns each
// W beat into a byte-strobed memory write and returns the B response.
module axi4_slave_write_ctrl #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int MEM_BYTES  = 12 * 1024
) (
  input  logic                                     aclk,
  input  logic                                     aresetn,
  input  logic [ID_WIDTH-1:0]                      awid,
  input  logic [ADDR_WIDTH-1:0]                    awaddr,
  input  logic [7:0]                               awlen,
  input  logic [2:0]                               awsize,
  input  logic [1:0]                               awburst,
  input  logic                                     awvalid,
  output logic                                     awready,
  input  logic [DATA_WIDTH-1:0]                    wdata,
  input  logic [STRB_WIDTH-1:0]                    wstrb,
  input  logic                                     wlast,
  input  logic                                     wvalid,
  output logic                                     wready,
  output logic [ID_WIDTH-1:0]                      bid,
  output logic [1:0]                               bresp,
  output logic                                     bvalid,
  input  logic                                     bready,
  output logic                                     mem_wr_en,
  output logic [ADDR_WIDTH-$clog2(STRB_WIDTH)-1:0] mem_wr_addr,
  output logic [DATA_WIDTH-1:0]                    mem_wr_data,
  output logic [STRB_WIDTH-1:0]                    mem_wr_strb
);
  localparam int LANE_BITS = $clog2(STRB_WIDTH);
  localparam int WORD_W    = ADDR_WIDTH - LANE_BITS;
  localparam int EXT_W     = ADDR_WIDTH + 1;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef logic [EXT_W-1:0] ext_addr_t;
  typedef enum logic [1:0] {IDLE, DATA, RESP} state_e;

  state_e                state_q, state_d;
  logic                  awready_q, awready_d;
  logic                  wready_q, wready_d;
  logic                  bvalid_q, bvalid_d;
  logic [ID_WIDTH-1:0]   bid_q, bid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  mem_wr_en_q, mem_wr_en_d;
  logic [WORD_W-1:0]     mem_wr_addr_q, mem_wr_addr_d;
  logic [DATA_WIDTH-1:0] mem_wr_data_q, mem_wr_data_d;
  logic [STRB_WIDTH-1:0] mem_wr_strb_q, mem_wr_strb_d;
  logic [ID_WIDTH-1:0]   awid_q, awid_d;
  logic [7:0]            awlen_q, awlen_d;
  logic [2:0]            awsize_q, awsize_d;
  logic [1:0]            awburst_q, awburst_d;
  ext_addr_t             addr_q, addr_d;
  ext_addr_t             wrap_base_q, wrap_base_d;
  ext_addr_t             wrap_end_q, wrap_end_d;
  logic [7:0]            beat_cnt_q, beat_cnt_d;
  logic                  err_q, err_d;
  logic                  bad_q, bad_d;

  ext_addr_t             beat_bytes, incr_addr, next_addr;
  ext_addr_t             aw_bytes, aw_bound, aw_base;
  logic                  aw_bad, beat_oob, beat_last, beat_drop, err_next;
  logic [STRB_WIDTH-1:0] lane_mask;
  int                    size_bytes, lane_lo, lane_hi;

  // Per-beat address/strobe arithmetic, kept one bit wider so overflow reads as out of range.
  always_comb begin
    beat_bytes = ext_addr_t'(1) << awsize_q;
    incr_addr  = (addr_q & ~(beat_bytes - ext_addr_t'(1))) + beat_bytes;
    next_addr  = incr_addr;
    case (awburst_q)
      BURST_FIXED: next_addr = addr_q;
      BURST_WRAP:  next_addr = (incr_addr == wrap_end_q) ? wrap_base_q : incr_addr;
      default:     next_addr = incr_addr;
    endcase
    beat_oob   = (addr_q + beat_bytes) > ext_addr_t'(MEM_BYTES);
    size_bytes = 1 << awsize_q;
    lane_lo    = int'(addr_q[LANE_BITS-1:0]);
    lane_hi    = (lane_lo & ~(size_bytes - 1)) + size_bytes - 1;
    for (int i = 0; i < STRB_WIDTH; i++) begin
      lane_mask[i] = (i >= lane_lo) && (i <= lane_hi);
    end
    aw_bytes = ext_addr_t'(1) << awsize;
    aw_bound = (ext_addr_t'(awlen) + ext_addr_t'(1)) << awsize;
    aw_base  = {1'b0, awaddr} & ~(aw_bound - ext_addr_t'(1));
    aw_bad   = (awburst == BURST_RSVD) || (awsize > 3'(LANE_BITS)) ||
               ((awburst == BURST_WRAP) &&
                (!(awlen inside {8'd1, 8'd3, 8'd7, 8'd15}) ||
                 (({1'b0, awaddr} & (aw_bytes - ext_addr_t'(1))) != '0)));
    beat_last = (beat_cnt_q == awlen_q);
    beat_drop = bad_q || beat_oob;
  end

  always_comb begin
    state_d       = state_q;
    awready_d     = awready_q;
    wready_d      = wready_q;
    bvalid_d      = bvalid_q;
    bid_d         = bid_q;
    bresp_d       = bresp_q;
    mem_wr_en_d   = 1'b0;
    mem_wr_addr_d = mem_wr_addr_q;
    mem_wr_data_d = mem_wr_data_q;
    mem_wr_strb_d = mem_wr_strb_q;
    awid_d        = awid_q;
    awlen_d       = awlen_q;
    awsize_d      = awsize_q;
    awburst_d     = awburst_q;
    addr_d        = addr_q;
    wrap_base_d   = wrap_base_q;
    wrap_end_d    = wrap_end_q;
    beat_cnt_d    = beat_cnt_q;
    err_d         = err_q;
    bad_d         = bad_q;
    err_next      = err_q;
    case (state_q)
      IDLE: begin
        awready_d = 1'b1;
        if (awvalid && awready_q) begin
          awid_d      = awid;
          awlen_d     = awlen;
          awsize_d    = awsize;
          awburst_d   = awburst;
          addr_d      = {1'b0, awaddr};
          wrap_base_d = aw_base;
          wrap_end_d  = aw_base + aw_bound;
          bad_d       = aw_bad;
          beat_cnt_d  = '0;
          err_d       = 1'b0;
          awready_d   = 1'b0;
          wready_d    = 1'b1;
          state_d     = DATA;
        end
      end
      DATA: begin
        if (wvalid && wready_q) begin
          // Illegal beats are still consumed so the burst length stays in step with the master.
          err_next      = err_q || beat_drop || (wlast != beat_last);
          err_d         = err_next;
          mem_wr_en_d   = !beat_drop;
          mem_wr_addr_d = addr_q[ADDR_WIDTH-1:LANE_BITS];
          mem_wr_data_d = wdata;
          mem_wr_strb_d = wstrb & lane_mask;
          beat_cnt_d    = beat_cnt_q + 8'd1;
          addr_d        = next_addr;
          if (beat_last) begin
            wready_d = 1'b0;
            bvalid_d = 1'b1;
            bid_d    = awid_q;
            bresp_d  = err_next ? RESP_SLVERR : RESP_OKAY;
            state_d  = RESP;
          end
        end
      end
      RESP: begin
        if (bready && bvalid_q) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q       <= IDLE;
      awready_q     <= 1'b0;
      wready_q      <= 1'b0;
      bvalid_q      <= 1'b0;
      bid_q         <= '0;
      bresp_q       <= RESP_OKAY;
      mem_wr_en_q   <= 1'b0;
      mem_wr_addr_q <= '0;
      mem_wr_data_q <= '0;
      mem_wr_strb_q <= '0;
      awid_q        <= '0;
      awlen_q       <= '0;
      awsize_q      <= '0;
      awburst_q     <= '0;
      addr_q        <= '0;
      wrap_base_q   <= '0;
      wrap_end_q    <= '0;
      beat_cnt_q    <= '0;
      err_q         <= 1'b0;
      bad_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      awready_q     <= awready_d;
      wready_q      <= wready_d;
      bvalid_q      <= bvalid_d;
      bid_q         <= bid_d;
      bresp_q       <= bresp_d;
      mem_wr_en_q   <= mem_wr_en_d;
      mem_wr_addr_q <= mem_wr_addr_d;
      mem_wr_data_q <= mem_wr_data_d;
      mem_wr_strb_q <= mem_wr_strb_d;
      awid_q        <= awid_d;
      awlen_q       <= awlen_d;
      awsize_q      <= awsize_d;
      awburst_q     <= awburst_d;
      addr_q        <= addr_d;
      wrap_base_q   <= wrap_base_d;
      wrap_end_q    <= wrap_end_d;
      beat_cnt_q    <= beat_cnt_d;
      err_q         <= err_d;
      bad_q         <= bad_d;
    end
  end

  assign awready     = awready_q;
  assign wready      = wready_q;
  assign bvalid      = bvalid_q;
  assign bid         = bid_q;
  assign bresp       = bresp_q;
  assign mem_wr_en   = mem_wr_en_q;
  assign mem_wr_addr = mem_wr_addr_q;
  assign mem_wr_data = mem_wr_data_q;
  assign mem_wr_strb = mem_wr_strb_q;

endmodule

// File: tb/tb_axi4_slave_write_ctrl.sv
// Bench for axi4_slave_write_ctrl: directed burst table, backpressure and
// mid-burst reset sequences, and random bursts against a byte-level model.
`timescale 1ns/1ps
module tb_axi4_slave_write_ctrl;
  localparam int DW = 64, AW = 32, IW = 4, SW = 8, LB = 3, WA = AW - LB;
  localparam int MEMB = 12 * 1024;

  logic          aclk = 1'b0, aresetn = 1'b0;
  logic [IW-1:0] awid = '0;
  logic [AW-1:0] awaddr = '0;
  logic [7:0]    awlen = '0;
  logic [2:0]    awsize = '0;
  logic [1:0]    awburst = '0;
  logic          awvalid = 1'b0, awready;
  logic [DW-1:0] wdata = '0;
  logic [SW-1:0] wstrb = '0;
  logic          wlast = 1'b0, wvalid = 1'b0, wready;
  logic [IW-1:0] bid;
  logic [1:0]    bresp;
  logic          bvalid, bready = 1'b0;
  logic          mem_wr_en;
  logic [WA-1:0] mem_wr_addr;
  logic [DW-1:0] mem_wr_data;
  logic [SW-1:0] mem_wr_strb;

  axi4_slave_write_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .MEM_BYTES(MEMB)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data), .mem_wr_strb(mem_wr_strb)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [WA-1:0] word;
    logic [SW-1:0] strb;
    logic [DW-1:0] data;
  } wr_t;

  typedef struct packed {
    logic [AW-1:0]        addr;
    logic [7:0]           len;
    logic [2:0]           size;
    logic [1:0]           burst;
    logic [SW-1:0]        strb;
    logic [7:0]           bad_last;
    logic [2:0]           n;
    logic [3:0][WA-1:0]   word;
    logic [3:0][SW-1:0]   estrb;
    logic [1:0]           resp;
  } vec_t;

  int      checks = 0, fails = 0, cyc = 0;
  wr_t     got_q[$], exp_q[$];
  int      got_cyc[$];
  wr_t     mon_w;
  logic [1:0]    exp_resp;
  logic [DW-1:0] beat_data [16];
  logic [SW-1:0] beat_strb [16];
  logic          beat_last [16];
  vec_t          vecs [10];

  always @(posedge aclk) cyc++;

  always @(negedge aclk) begin
    if (aresetn && mem_wr_en) begin
      mon_w.word = mem_wr_addr;
      mon_w.strb = mem_wr_strb;
      mon_w.data = mem_wr_data;
      got_q.push_back(mon_w);
      got_cyc.push_back(cyc);
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mkVec(logic [AW-1:0] addr, logic [7:0] len, logic [2:0] size,
                                 logic [1:0] burst, logic [SW-1:0] strb, logic [7:0] bad_last,
                                 logic [2:0] n, logic [WA-1:0] w0, logic [WA-1:0] w1,
                                 logic [WA-1:0] w2, logic [WA-1:0] w3, logic [SW-1:0] s0,
                                 logic [SW-1:0] s1, logic [SW-1:0] s2, logic [SW-1:0] s3,
                                 logic [1:0] resp);
    vec_t v;
    v.addr = addr; v.len = len; v.size = size; v.burst = burst; v.strb = strb;
    v.bad_last = bad_last; v.n = n; v.resp = resp;
    v.word[0] = w0; v.word[1] = w1; v.word[2] = w2; v.word[3] = w3;
    v.estrb[0] = s0; v.estrb[1] = s1; v.estrb[2] = s2; v.estrb[3] = s3;
    return v;
  endfunction

  // Reference model: each beat's byte address from the burst rules in closed form,
  // strobe from which bytes of the memory word fall inside the beat's container.
  task automatic modelBurst(input logic [AW-1:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
    longint a0 = {32'b0, addr};
    longint bytes = longint'(1) << size;
    longint boundary = (longint'(len) + 1) * bytes;
    longint base = a0 - (a0 % boundary);
    bit bad, err;
    wr_t w;
    exp_q.delete();
    bad = (burst == 2'b11) || (size > LB) ||
          (burst == 2'b10 && (!(len inside {8'd1, 8'd3, 8'd7, 8'd15}) || (a0 % bytes) != 0));
    err = bad;
    for (int n = 0; n <= int'(len); n++) begin
      longint ba;
      if (burst == 2'b00) ba = a0;
      else if (burst == 2'b01) ba = (n == 0) ? a0 : (a0 - a0 % bytes) + n * bytes;
      else ba = base + ((a0 - base) + n * bytes) % boundary;
      if (beat_last[n] != (n == int'(len))) err = 1;
      if (!bad && ba + bytes > MEMB) err = 1;
      if (!bad && ba + bytes <= MEMB) begin
        w.word = WA'(ba / SW);
        for (int l = 0; l < SW; l++) begin
          longint b = (ba / SW) * SW + l;
          w.strb[l] = beat_strb[n][l] && (b >= ba) && (b < (ba - ba % bytes) + bytes);
        end
        w.data = beat_data[n];
        exp_q.push_back(w);
      end
    end
    exp_resp = err ? 2'b10 : 2'b00;
  endtask

  // One full burst: AW handshake, W beats back to back, B handshake after bdelay cycles.
  task automatic applyStimulus(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                               input logic [7:0] len, input logic [2:0] size,
                               input logic [1:0] burst, input int bdelay, input logic [1:0] resp);
    int guard;
    got_q.delete();
    got_cyc.delete();
    @(negedge aclk);
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    guard = 0;
    while (awready !== 1'b1 && guard < 20) begin @(negedge aclk); guard++; end
    checkOutput("aw_accept", awready, 1'b1);
    if (awready !== 1'b1) begin awvalid = 1'b0; return; end
    @(negedge aclk);
    awvalid = 1'b0;
    checkOutput("ready_after_aw", {wready, awready}, 2'b10);
    for (int n = 0; n <= int'(len); n++) begin
      wvalid = 1'b1; wdata = beat_data[n]; wstrb = beat_strb[n]; wlast = beat_last[n];
      guard = 0;
      while (wready !== 1'b1 && guard < 20) begin @(negedge aclk); guard++; end
      if (wready !== 1'b1) begin
        checkOutput("w_accept", wready, 1'b1);
        wvalid = 1'b0;
        return;
      end
      @(negedge aclk);
    end
    wvalid = 1'b0; wlast = 1'b0;
    checkOutput("b_after_last", {bvalid, wready}, 2'b10);
    checkOutput("bid", bid, id);
    checkOutput("bresp", bresp, resp);
    for (int d = 0; d < bdelay; d++) begin
      @(negedge aclk);
      checkOutput("b_hold", {bvalid, bid, bresp, awready, wready}, {1'b1, id, resp, 1'b0, 1'b0});
    end
    bready = 1'b1;
    @(negedge aclk);
    bready = 1'b0;
    checkOutput("b_release", {bvalid, awready}, 2'b01);
  endtask

  task automatic compareWrites(input logic [7:0] len);
    int m;
    checkOutput("n_writes", got_q.size(), exp_q.size());
    m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < m; i++) begin
      checkOutput($sformatf("wr%0d_word", i), got_q[i].word, exp_q[i].word);
      checkOutput($sformatf("wr%0d_strb", i), got_q[i].strb, exp_q[i].strb);
      checkOutput($sformatf("wr%0d_data", i), got_q[i].data, exp_q[i].data);
    end
    if (len > 0 && exp_q.size() == int'(len) + 1 && got_q.size() == exp_q.size())
      checkOutput("back_to_back", got_cyc[len] - got_cyc[0], len);
  endtask

  task automatic runVector(input int v, input int bdelay);
    wr_t w;
    for (int n = 0; n < 16; n++) begin
      beat_data[n] = 64'h1122334455667788 + 64'(n);
      beat_strb[n] = vecs[v].strb;
      beat_last[n] = (n == int'(vecs[v].len)) || (n == int'(vecs[v].bad_last));
    end
    exp_q.delete();
    for (int i = 0; i < int'(vecs[v].n); i++) begin
      w.word = vecs[v].word[i]; w.strb = vecs[v].estrb[i]; w.data = beat_data[i];
      exp_q.push_back(w);
    end
    applyStimulus(4'(v + 3), vecs[v].addr, vecs[v].len, vecs[v].size, vecs[v].burst, bdelay, vecs[v].resp);
    compareWrites(vecs[v].len);
  endtask

  task automatic randomBurst();
    logic [7:0] wl [4] = '{8'd1, 8'd3, 8'd7, 8'd15};
    logic [2:0]    sz;
    logic [1:0]    bu;
    logic [7:0]    ln;
    logic [AW-1:0] ad;
    int r = $urandom_range(0, 19);
    bu = (r == 0) ? 2'b11 : 2'(r % 3);
    sz = ($urandom_range(0, 9) == 0) ? 3'd4 : 3'($urandom_range(0, 3));
    if (bu == 2'b10) ln = ($urandom_range(0, 7) == 0) ? 8'd2 : wl[$urandom_range(0, 3)];
    else ln = 8'($urandom_range(0, 7));
    ad = AW'($urandom_range(0, MEMB + 64));
    if ($urandom_range(0, 3) != 0) ad = ad & ~((32'd1 << sz) - 32'd1);
    for (int n = 0; n <= int'(ln); n++) begin
      beat_data[n] = {$urandom, $urandom};
      beat_strb[n] = SW'($urandom);
      beat_last[n] = (n == int'(ln));
    end
    if ($urandom_range(0, 7) == 0) begin
      r = $urandom_range(0, int'(ln));
      beat_last[r] = ~beat_last[r];
    end
    modelBurst(ad, ln, sz, bu);
    applyStimulus(IW'($urandom), ad, ln, sz, bu, $urandom_range(0, 3), exp_resp);
    compareWrites(ln);
  endtask

  initial begin
    int bv;
    vecs[0] = mkVec(32'h40,   8'd0, 3'd3, 2'b01, 8'hFF, 8'hFF, 3'd1, 29'h8,   29'h0,   29'h0,   29'h0,   8'hFF, 8'h00, 8'h00, 8'h00, 2'b00);
    vecs[1] = mkVec(32'h100,  8'd3, 3'd3, 2'b01, 8'hFF, 8'hFF, 3'd4, 29'h20,  29'h21,  29'h22,  29'h23,  8'hFF, 8'hFF, 8'hFF, 8'hFF, 2'b00);
    vecs[2] = mkVec(32'h3,    8'd1, 3'd0, 2'b00, 8'hFF, 8'hFF, 3'd2, 29'h0,   29'h0,   29'h0,   29'h0,   8'h08, 8'h08, 8'h00, 8'h00, 2'b00);
    vecs[3] = mkVec(32'h5,    8'd1, 3'd2, 2'b01, 8'hFF, 8'hFF, 3'd2, 29'h0,   29'h1,   29'h0,   29'h0,   8'hE0, 8'h0F, 8'h00, 8'h00, 2'b00);
    vecs[4] = mkVec(32'h18,   8'd3, 3'd3, 2'b10, 8'hFF, 8'hFF, 3'd4, 29'h3,   29'h0,   29'h1,   29'h2,   8'hFF, 8'hFF, 8'hFF, 8'hFF, 2'b00);
    vecs[5] = mkVec(32'h2FF8, 8'd1, 3'd3, 2'b01, 8'hFF, 8'hFF, 3'd1, 29'h5FF, 29'h0,   29'h0,   29'h0,   8'hFF, 8'h00, 8'h00, 8'h00, 2'b10);
    vecs[6] = mkVec(32'h200,  8'd3, 3'd3, 2'b11, 8'hFF, 8'hFF, 3'd0, 29'h0,   29'h0,   29'h0,   29'h0,   8'h00, 8'h00, 8'h00, 8'h00, 2'b10);
    vecs[7] = mkVec(32'h300,  8'd3, 3'd3, 2'b01, 8'hFF, 8'd1,  3'd4, 29'h60,  29'h61,  29'h62,  29'h63,  8'hFF, 8'hFF, 8'hFF, 8'hFF, 2'b10);
    vecs[8] = mkVec(32'h0,    8'd1, 3'd4, 2'b01, 8'hFF, 8'hFF, 3'd0, 29'h0,   29'h0,   29'h0,   29'h0,   8'h00, 8'h00, 8'h00, 8'h00, 2'b10);
    vecs[9] = mkVec(32'h40,   8'd2, 3'd3, 2'b10, 8'hFF, 8'hFF, 3'd0, 29'h0,   29'h0,   29'h0,   29'h0,   8'h00, 8'h00, 8'h00, 8'h00, 2'b10);

    repeat (3) @(negedge aclk);
    checkOutput("reset_state", {awready, wready, bvalid, bid, bresp, mem_wr_en, mem_wr_addr, mem_wr_data, mem_wr_strb}, '0);
    aresetn = 1'b1;
    #1 checkOutput("awready_before_edge", awready, 1'b0);
    @(negedge aclk);
    checkOutput("awready_after_reset", awready, 1'b1);

    for (int v = 0; v < 10; v++) runVector(v, v % 3);

    $display("[TB] B-channel backpressure for 5 cycles");
    runVector(1, 5);

    $display("[TB] reset in the middle of a 4-beat burst");
    for (int n = 0; n < 4; n++) begin
      beat_data[n] = 64'hA5A5_0000_0000_0000 + 64'(n); beat_strb[n] = 8'hFF; beat_last[n] = (n == 3);
    end
    @(negedge aclk);
    awid = 4'h9; awaddr = 32'h400; awlen = 8'd3; awsize = 3'd3; awburst = 2'b01; awvalid = 1'b1;
    @(negedge aclk);
    awvalid = 1'b0;
    for (int n = 0; n < 2; n++) begin
      wvalid = 1'b1; wdata = beat_data[n]; wstrb = beat_strb[n]; wlast = beat_last[n];
      @(negedge aclk);
    end
    wdata = beat_data[2]; wlast = beat_last[2];
    #2 aresetn = 1'b0;
    #1 checkOutput("async_reset_outputs", {awready, wready, bvalid, bid, bresp, mem_wr_en, mem_wr_addr, mem_wr_data, mem_wr_strb}, '0);
    wvalid = 1'b0; wlast = 1'b0;
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    bv = 0;
    repeat (6) begin
      @(negedge aclk);
      if (bvalid) bv++;
    end
    checkOutput("no_b_after_reset", bv, 0);
    checkOutput("awready_after_midreset", awready, 1'b1);
    runVector(1, 0);

    $display("[TB] random bursts against model");
    for (int t = 0; t < 60; t++) randomBurst();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
